// File: rtl/counter_sequencer_pkg.sv
// Shared definitions for the counter run-control sequencer: state encoding,
// run-mode codes and the default prescaler division.
package counter_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CLEAR    = 3'd1,
    ST_RUN_UP   = 3'd2,
    ST_RUN_DOWN = 3'd3,
    ST_PAUSE    = 3'd4,
    ST_DONE     = 3'd5
  } state_t;

  // modeSel code 3 is decoded as free-run alongside code 0.
  localparam logic [1:0] MODE_FREE    = 2'd0;
  localparam logic [1:0] MODE_BOUNCE  = 2'd1;
  localparam logic [1:0] MODE_ONESHOT = 2'd2;

  // 1 kHz step rate from a 50 MHz system clock.
  localparam int TICK_DIV_DEFAULT = 50000;

  function automatic logic is_run(input state_t s);
    return (s == ST_RUN_UP) || (s == ST_RUN_DOWN);
  endfunction

endpackage

// File: rtl/counter_sequencer_tick_gen.sv
// Step prescaler: counts 0..TICK_DIV-1 while run is high, holds its value
// while run is low, and returns to 0 on clr. tick marks the terminal count.
module tick_gen
  import counter_sequencer_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEFAULT
) (
  input  logic clk,
  input  logic init,
  input  logic run,
  input  logic clr,
  output logic tick
);

  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q;

  assign tick = (cnt_q == LAST);

  // Prescaler register: clear wins over run; wraps to 0 after the terminal value.
  always_ff @(posedge clk) begin
    if (init) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (run) begin
      cnt_q <= tick ? '0 : cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/counter_sequencer.sv
// Run-control FSM for the up/down counter. Converts debounced button pulses
// into counter init/enable/down controls, paced by the tick_gen prescaler,
// with free-run, bounce and one-shot behaviour against a latched limit.
module counter_sequencer
  import counter_sequencer_pkg::*;
#(
  parameter int WIDTH    = 12,
  parameter int TICK_DIV = TICK_DIV_DEFAULT
) (
  input  logic             clk,
  input  logic             init,
  input  logic             startBtn,
  input  logic             stopBtn,
  input  logic             clearBtn,
  input  logic             dirSel,
  input  logic [1:0]       modeSel,
  input  logic [WIDTH-1:0] upperLimit,
  input  logic [WIDTH-1:0] count,
  output logic             counterInit,
  output logic             counterEnable,
  output logic             counterDown,
  output logic             busy,
  output logic             done,
  output state_t           dbg_state
);

  state_t           state_q, state_d;
  logic [1:0]       mode_q, mode_d;
  logic [WIDTH-1:0] limit_q, limit_d;
  logic             dir_q, dir_d;
  logic             pulse;
  logic             presc_clr;
  logic             presc_run;
  logic             tick;

  assign dbg_state = state_q;

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
    .clk  (clk),
    .init (init),
    .run  (presc_run),
    .clr  (presc_clr),
    .tick (tick)
  );

  // Next-state, latch and step decisions. Button priority: clear > stop > start.
  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    limit_d   = limit_q;
    dir_d     = dir_q;
    pulse     = 1'b0;
    presc_clr = 1'b0;
    presc_run = 1'b0;
    if (clearBtn) begin
      state_d   = ST_CLEAR;
      dir_d     = 1'b0;
      presc_clr = 1'b1;
    end else begin
      case (state_q)
        ST_CLEAR: state_d = ST_IDLE;
        ST_IDLE, ST_DONE: begin
          if (startBtn && !stopBtn) begin
            mode_d    = modeSel;
            limit_d   = upperLimit;
            dir_d     = dirSel;
            presc_clr = 1'b1;
            state_d   = dirSel ? ST_RUN_DOWN : ST_RUN_UP;
          end
        end
        ST_RUN_UP, ST_RUN_DOWN: begin
          // A stop freezes the prescaler, except on a tick, which is consumed
          // here and so must wrap rather than fire again on resume.
          presc_run = !stopBtn || tick;
          if (tick) begin
            case (mode_q)
              MODE_BOUNCE: begin
                if (!dir_q && (count >= limit_q)) begin
                  dir_d   = 1'b1;
                  state_d = ST_RUN_DOWN;
                end else if (dir_q && (count == '0)) begin
                  dir_d   = 1'b0;
                  state_d = ST_RUN_UP;
                end else begin
                  pulse = 1'b1;
                end
              end
              MODE_ONESHOT: begin
                if ((!dir_q && (count >= limit_q)) || (dir_q && (count == '0))) begin
                  state_d = ST_DONE;
                end else begin
                  pulse = 1'b1;
                end
              end
              default: pulse = 1'b1;
            endcase
          end
          // The limit action lands first; a one-shot that just finished stays done.
          if (stopBtn && (state_d != ST_DONE)) begin
            state_d = ST_PAUSE;
          end
        end
        ST_PAUSE: begin
          if (startBtn && !stopBtn) begin
            state_d = dir_q ? ST_RUN_DOWN : ST_RUN_UP;
          end
        end
        default: state_d = ST_CLEAR;
      endcase
    end
  end

  // State, latched run parameters and registered outputs derived from next state.
  always_ff @(posedge clk) begin
    if (init) begin
      state_q       <= ST_CLEAR;
      mode_q        <= MODE_FREE;
      limit_q       <= '0;
      dir_q         <= 1'b0;
      counterInit   <= 1'b1;
      counterEnable <= 1'b0;
      counterDown   <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      state_q       <= state_d;
      mode_q        <= mode_d;
      limit_q       <= limit_d;
      dir_q         <= dir_d;
      counterInit   <= (state_d == ST_CLEAR);
      counterEnable <= pulse;
      counterDown   <= dir_d;
      busy          <= is_run(state_d);
      done          <= (state_d == ST_DONE);
    end
  end

endmodule

// File: tb/tb_counter_sequencer.sv
// Bench for counter_sequencer with TICK_DIV=4 driving a behavioural model of
// the 12-bit up/down counter, which feeds back into count.
module tb_counter_sequencer;
  import counter_sequencer_pkg::*;

  localparam int W    = 12;
  localparam int TICK = 4;

  logic         clk;
  logic         init;
  logic         startBtn, stopBtn, clearBtn, dirSel;
  logic [1:0]   modeSel;
  logic [W-1:0] upperLimit;
  logic [W-1:0] count;
  logic         counterInit, counterEnable, counterDown, busy, done;
  state_t       dbg_state;

  logic         pre_en;
  logic [W-1:0] pre_val;

  int n_checks = 0;
  int n_errors = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] sb_exp;
  bit           sb_on   = 1'b0;
  bit           sb_pend = 1'b0;

  typedef struct {
    logic [1:0]   mode;
    logic         dir;
    logic [W-1:0] lim;
    logic [W-1:0] pre;
    int           n;
    logic [W-1:0] exp_cnt;
    logic         exp_busy;
    logic         exp_done;
    logic         exp_down;
  } vec_t;

  vec_t vecs[8];

  counter_sequencer #(.WIDTH(W), .TICK_DIV(TICK)) dut (
    .clk           (clk),
    .init          (init),
    .startBtn      (startBtn),
    .stopBtn       (stopBtn),
    .clearBtn      (clearBtn),
    .dirSel        (dirSel),
    .modeSel       (modeSel),
    .upperLimit    (upperLimit),
    .count         (count),
    .counterInit   (counterInit),
    .counterEnable (counterEnable),
    .counterDown   (counterDown),
    .busy          (busy),
    .done          (done),
    .dbg_state     (dbg_state)
  );

  // Clock and global watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  // Counter model: init clears, bench preload, else step on enable.
  initial count = '0;
  always @(posedge clk) begin
    if (counterInit)        count <= '0;
    else if (pre_en)        count <= pre_val;
    else if (counterEnable) count <= counterDown ? count - 12'd1 : count + 12'd1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard: one cycle after each enable pulse, the counter value must match the queue head.
  always begin
    @(posedge clk);
    #2;
    if (sb_on && sb_pend) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL sb_underflow: unexpected step, count=%0d", count);
      end else begin
        sb_exp = exp_q.pop_front();
        check("sb_count", count, sb_exp);
      end
    end
    sb_pend = counterEnable;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press_clear();
    clearBtn = 1'b1;
    step(1);
    clearBtn = 1'b0;
    step(1);
  endtask

  task automatic preload(input logic [W-1:0] v);
    pre_val = v;
    pre_en  = 1'b1;
    step(1);
    pre_en  = 1'b0;
  endtask

  task automatic start(input logic [1:0] m, input logic d, input logic [W-1:0] lim);
    modeSel    = m;
    dirSel     = d;
    upperLimit = lim;
    startBtn   = 1'b1;
    step(1);
    startBtn   = 1'b0;
  endtask

  task automatic push_seq(input logic [W-1:0] a, input logic [W-1:0] b, input int len, input bit down);
    logic [W-1:0] v;
    v = a;
    for (int i = 0; i < len; i++) begin
      exp_q.push_back(v);
      v = down ? v - 12'd1 : v + 12'd1;
    end
    if (v != b + (down ? -12'd1 : 12'd1)) begin
      $display("note: push_seq endpoint %0d", b);
    end
  endtask

  initial begin
    int seen;
    vecs[0] = '{MODE_FREE,    1'b0, 12'd0, 12'd10, 13, 12'd13,   1'b1, 1'b0, 1'b0};
    vecs[1] = '{MODE_FREE,    1'b1, 12'd0, 12'd1,  13, 12'd4094, 1'b1, 1'b0, 1'b1};
    vecs[2] = '{MODE_ONESHOT, 1'b0, 12'd5, 12'd0,  30, 12'd5,    1'b0, 1'b1, 1'b0};
    vecs[3] = '{MODE_ONESHOT, 1'b1, 12'd7, 12'd2,  20, 12'd0,    1'b0, 1'b1, 1'b1};
    vecs[4] = '{MODE_BOUNCE,  1'b0, 12'd0, 12'd0,  14, 12'd0,    1'b1, 1'b0, 1'b1};
    vecs[5] = '{2'd3,         1'b0, 12'd2, 12'd2,  9,  12'd4,    1'b1, 1'b0, 1'b0};
    vecs[6] = '{MODE_ONESHOT, 1'b0, 12'd5, 12'd9,  6,  12'd9,    1'b0, 1'b1, 1'b0};
    vecs[7] = '{MODE_BOUNCE,  1'b1, 12'd6, 12'd3,  17, 12'd0,    1'b1, 1'b0, 1'b0};

    init = 1'b1; startBtn = 1'b0; stopBtn = 1'b0; clearBtn = 1'b0;
    dirSel = 1'b0; modeSel = 2'd0; upperLimit = '0; pre_en = 1'b0; pre_val = '0;

    // Reset: init held for three edges, counterInit stays one cycle past release.
    step(1);
    check("rst_init", counterInit, 1);
    check("rst_enable", counterEnable, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_down", counterDown, 0);
    check("rst_state", dbg_state, ST_CLEAR);
    step(2);
    init = 1'b0;
    check("rst_init_tail", counterInit, 1);
    step(1);
    check("rst_init_off", counterInit, 0);
    check("rst_idle", dbg_state, ST_IDLE);
    check("rst_count", count, 0);

    // Free-run wrap from 4095 and first-pulse latency of TICK cycles.
    sb_on = 1'b1;
    exp_q.push_back(12'd0);
    exp_q.push_back(12'd1);
    preload(12'd4095);
    start(MODE_FREE, 1'b0, 12'd0);
    check("free_busy", busy, 1);
    check("free_down", counterDown, 0);
    for (int i = 1; i < TICK; i++) begin
      check("free_latency_quiet", counterEnable, 0);
      step(1);
    end
    check("free_latency_quiet", counterEnable, 0);
    step(1);
    check("free_first_pulse", counterEnable, 1);
    step(1);
    check("free_wrap", count, 0);
    check("free_pulse_width", counterEnable, 0);
    step(3);
    check("free_period", counterEnable, 1);
    step(2);
    press_clear();
    check("free_sb_drained", exp_q.size(), 0);

    // Bounce between 0 and 3: reversals consume a tick without a pulse.
    push_seq(12'd1, 12'd3, 3, 1'b0);
    push_seq(12'd2, 12'd0, 3, 1'b1);
    start(MODE_BOUNCE, 1'b0, 12'd3);
    step(16);
    check("bounce_top_nopulse", counterEnable, 0);
    check("bounce_top_down", counterDown, 1);
    check("bounce_top_count", count, 3);
    step(16);
    check("bounce_bot_nopulse", counterEnable, 0);
    check("bounce_bot_up", counterDown, 0);
    check("bounce_bot_count", count, 0);
    check("bounce_busy", busy, 1);
    step(2);
    press_clear();
    check("bounce_sb_drained", exp_q.size(), 0);

    // One-shot up to 5, then a fresh start downward from DONE.
    push_seq(12'd1, 12'd5, 5, 1'b0);
    start(MODE_ONESHOT, 1'b0, 12'd5);
    step(26);
    check("oneshot_up_done", done, 1);
    check("oneshot_up_busy", busy, 0);
    check("oneshot_up_count", count, 5);
    check("oneshot_up_state", dbg_state, ST_DONE);
    push_seq(12'd4, 12'd0, 5, 1'b1);
    start(MODE_ONESHOT, 1'b1, 12'd5);
    check("oneshot_restart_done", done, 0);
    check("oneshot_restart_busy", busy, 1);
    check("oneshot_restart_down", counterDown, 1);
    step(26);
    check("oneshot_dn_done", done, 1);
    check("oneshot_dn_count", count, 0);
    press_clear();
    check("oneshot_sb_drained", exp_q.size(), 0);

    // Pause at count 2 with prescaler 1, hold 20 cycles, resume.
    exp_q.push_back(12'd1);
    exp_q.push_back(12'd2);
    exp_q.push_back(12'd3);
    start(MODE_FREE, 1'b0, 12'd0);
    step(9);
    stopBtn = 1'b1;
    step(1);
    stopBtn = 1'b0;
    check("pause_state", dbg_state, ST_PAUSE);
    check("pause_busy", busy, 0);
    check("pause_count", count, 2);
    seen = 0;
    repeat (20) begin
      step(1);
      seen += int'(counterEnable);
    end
    check("pause_quiet", seen, 0);
    startBtn = 1'b1;
    step(1);
    startBtn = 1'b0;
    check("resume_busy", busy, 1);
    step(1);
    check("resume_quiet1", counterEnable, 0);
    step(1);
    check("resume_quiet2", counterEnable, 0);
    step(1);
    check("resume_pulse", counterEnable, 1);
    check("resume_dir", counterDown, 0);
    step(2);
    press_clear();
    check("pause_sb_drained", exp_q.size(), 0);
    sb_on = 1'b0;

    // Clear and start in the same cycle while running: clear wins.
    start(MODE_FREE, 1'b0, 12'd0);
    step(6);
    clearBtn = 1'b1;
    startBtn = 1'b1;
    step(1);
    clearBtn = 1'b0;
    startBtn = 1'b0;
    check("clrstart_init", counterInit, 1);
    check("clrstart_state", dbg_state, ST_CLEAR);
    check("clrstart_busy", busy, 0);
    step(1);
    check("clrstart_init_off", counterInit, 0);
    check("clrstart_idle", dbg_state, ST_IDLE);
    check("clrstart_count", count, 0);
    check("clrstart_busy2", busy, 0);

    // Table of run scenarios, each from a cleared IDLE with a preloaded count.
    for (int k = 0; k < 8; k++) begin
      press_clear();
      preload(vecs[k].pre);
      start(vecs[k].mode, vecs[k].dir, vecs[k].lim);
      step(vecs[k].n);
      check($sformatf("vec%0d_count", k), count, vecs[k].exp_cnt);
      check($sformatf("vec%0d_busy", k), busy, vecs[k].exp_busy);
      check($sformatf("vec%0d_done", k), done, vecs[k].exp_done);
      check($sformatf("vec%0d_down", k), counterDown, vecs[k].exp_down);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
